twiddle_mul_stage4: RTL and testbench
=====================================

TWIDDLE_MUL_STAGE4 -- requirements
Module: twiddle_mul_stage4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 Port `clk` SHALL be an input, 1 bit: rising-edge clock for all state.
REQ-003 Port `rst` SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port `in_valid` SHALL be an input, 1 bit: input sample qualifier; one complex sample per cycle while high.
REQ-005 Port `in_start` SHALL be an input, 1 bit: marks the first sample of a 32-sample frame; sampled only with in_valid.
REQ-006 Port `in_r` SHALL be an input, 16 bits signed: real part of the sample.
REQ-007 Port `in_i` SHALL be an input, 16 bits signed: imaginary part of the sample.
REQ-008 Port `rom_4_counter` SHALL be an output, 2 bits: twiddle index driven to the 4-entry twiddle ROM.
REQ-009 Port `w_r` SHALL be an input, 9 bits signed: twiddle real part returned combinationally by the ROM, Q1.7 (128 = 1.0).
REQ-010 Port `w_i` SHALL be an input, 9 bits signed: twiddle imaginary part, Q1.7.
REQ-011 Port `out_valid` SHALL be an output, 1 bit: output sample qualifier.
REQ-012 Port `out_last` SHALL be an output, 1 bit: high with the 32nd output sample of a frame.
REQ-013 Port `out_r` SHALL be an output, 16 bits signed: real part of in*W.
REQ-014 Port `out_i` SHALL be an output, 16 bits signed: imaginary part of in*W.

Function
REQ-015 A 5-bit sample counter `cnt` SHALL increment by one on every cycle with in_valid=1, wrapping 31->0.
REQ-016 When in_valid=1 and in_start=1, the current sample SHALL be treated as cnt=0, and cnt SHALL become 1; in_start overrides any count in progress.
REQ-017 rom_4_counter SHALL equal cnt[1:0] when cnt[2]=1, and 2'd0 when cnt[2]=0 (W=128+j0, pass-through); it is derived from the effective cnt of the current input cycle.
REQ-018 The ROM response (w_r, w_i) SHALL be captured in the same cycle as in_r/in_i, in pipeline stage 1.
REQ-019 Stage 2 SHALL register the four 25-bit products in_r*w_r, in_i*w_i, in_r*w_i and in_i*w_r.
REQ-020 Stage 3 SHALL form re = rr-ii and im = ri+ir at 26 bits, scale each by >>>7 (arithmetic), saturate to [-32768, 32767], and register the result.
REQ-021 Latency SHALL be exactly 3 cycles: out_valid at cycle n+3 equals in_valid at cycle n; bubbles SHALL propagate unchanged.
REQ-022 out_last SHALL be high exactly when the output sample entered with cnt=31.
REQ-023 When out_valid=0, out_r and out_i SHALL hold their last value.
REQ-024 The block SHALL have no backpressure; the downstream stage always accepts.

Reset
REQ-025 While rst=1 at a clock edge, cnt SHALL become 0 and all pipeline valid/last flags and data registers SHALL become 0.
REQ-026 Outputs after reset SHALL be out_valid=0, out_last=0, out_r=0, out_i=0, and rom_4_counter=0.
REQ-027 Samples in flight when rst is asserted SHALL be discarded, with no partial output.
REQ-028 The first in_valid after reset SHALL be treated as cnt=0, even without in_start.

Configuration
REQ-029 Macro TWIDDLE_ROUND_EN, when defined, SHALL cause stage 3 to add 64 before the >>>7 (round half up).
REQ-030 Without TWIDDLE_ROUND_EN, the >>>7 SHALL truncate toward minus infinity; there is no other difference.

Verification
REQ-031 Scenario: reset, then 32 consecutive valid samples in=(1000, -500) with in_start on the first.
- Required response: rom_4_counter = 0,0,0,0,0,1,2,3 repeating.
- Required response: out = (1000, -500) for cnt with cnt[2]=0.
- Required response: out_last only on the 32nd output, 3 cycles after the last input.
REQ-032 Scenario: cnt=6 (W=-j128), in=(300, 200) -> out=(200, -300).
REQ-033 Scenario: cnt=5 (W=90-j90), in=(100, 0), per build:
- With TWIDDLE_ROUND_EN: out=(70, -70).
- Without TWIDDLE_ROUND_EN: out=(70, -71).
REQ-034 Scenario: cnt=7 (W=-90-j90), in=(-32768, -32768) -> out_r saturates to -32768 or 0 as computed: re=0, im=+46080 saturates to 32767; required out=(0, 32767).
REQ-035 Scenario: alternating in_valid 1/0 for 64 cycles, with in_start asserted at sample 10, then rst asserted mid-frame.
- Required response: cnt restarts at 10 so the next output is the cnt=0 sample.
- Required response: outputs keep the 3-cycle spacing with held data during bubbles.
- Required response: rst clears out_valid on the next cycle and no stale sample emerges.

Source files
------------

// File: rtl/twiddle_mul_stage4.sv
// ---------------------------------------------------------------------------
// twiddle_mul_stage4
//
// Twiddle-factor multiplier for the radix stage that works on 32-sample
// frames. Each incoming complex sample is multiplied by a twiddle factor
// taken from an external 4-entry ROM. The index is driven out on
// rom_4_counter and the twiddle comes back combinationally on w_r/w_i.
// Samples whose frame position has bit 2 clear use index 0, which the ROM
// holds as 1.0 (128 + j0), so they pass through unchanged.
//
// Pipeline (fixed 3-cycle latency, no backpressure):
//   stage 1 : register the sample, the ROM twiddle and the valid/last flags
//   stage 2 : register the four 25-bit partial products
//   stage 3 : combine to re/im, scale by >>>7, saturate to 16 bits
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   in_valid       input sample qualifier
//   in_start       first sample of a frame (used only with in_valid)
//   in_r, in_i     signed 16-bit input sample
//   rom_4_counter  twiddle ROM index
//   w_r, w_i       signed Q1.7 twiddle from the ROM
//   out_valid      output sample qualifier
//   out_last       marks the 32nd output sample of a frame
//   out_r, out_i   signed 16-bit product, held while out_valid is low
//
// Build option
//   TWIDDLE_ROUND_EN : add 64 before the >>>7 (round half up). When the
//                      macro is not defined, the shift truncates toward
//                      minus infinity.
// ---------------------------------------------------------------------------
module twiddle_mul_stage4 (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_start,
    input  logic signed [15:0] in_r,
    input  logic signed [15:0] in_i,
    output logic [1:0]         rom_4_counter,
    input  logic signed [8:0]  w_r,
    input  logic signed [8:0]  w_i,
    output logic               out_valid,
    output logic               out_last,
    output logic signed [15:0] out_r,
    output logic signed [15:0] out_i
);

    // -----------------------------------------------------------------------
    // Frame position counter
    // -----------------------------------------------------------------------
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] cnt_eff;

    // in_start forces the current sample to position 0, whatever count
    // was in progress.
    always_comb begin
        cnt_eff = (in_valid && in_start) ? 5'd0 : cnt_q;
        cnt_d   = in_valid ? (cnt_eff + 5'd1) : cnt_q;
    end

    assign rom_4_counter = cnt_eff[2] ? cnt_eff[1:0] : 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: sample + twiddle capture
    // -----------------------------------------------------------------------
    logic               s1_valid_q, s1_last_q;
    logic signed [15:0] s1_r_q, s1_i_q;
    logic signed [8:0]  s1_wr_q, s1_wi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_r_q     <= '0;
            s1_i_q     <= '0;
            s1_wr_q    <= '0;
            s1_wi_q    <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_valid && (cnt_eff == 5'd31);
            s1_r_q     <= in_r;
            s1_i_q     <= in_i;
            s1_wr_q    <= w_r;
            s1_wi_q    <= w_i;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: partial products
    // -----------------------------------------------------------------------
    logic signed [24:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [24:0] rr_q, ii_q, ri_q, ir_q;
    logic               s2_valid_q, s2_last_q;

    // 16x9 signed fits in 25 bits; the largest magnitude is
    // (-32768)*(-256) = 2^23.
    always_comb begin
        rr_d = 25'(s1_r_q) * 25'(s1_wr_q);
        ii_d = 25'(s1_i_q) * 25'(s1_wi_q);
        ri_d = 25'(s1_r_q) * 25'(s1_wi_q);
        ir_d = 25'(s1_i_q) * 25'(s1_wr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            rr_q       <= '0;
            ii_q       <= '0;
            ri_q       <= '0;
            ir_q       <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            rr_q       <= rr_d;
            ii_q       <= ii_d;
            ri_q       <= ri_d;
            ir_q       <= ir_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: combine, scale, saturate
    // -----------------------------------------------------------------------
    logic signed [25:0] re_sum, im_sum;
    logic signed [25:0] re_sh, im_sh;
    logic signed [15:0] re_sat, im_sat;

    always_comb begin
        re_sum = 26'(rr_q) - 26'(ii_q);
        im_sum = 26'(ri_q) + 26'(ir_q);
`ifdef TWIDDLE_ROUND_EN
        re_sh = (re_sum + 26'sd64) >>> 7;
        im_sh = (im_sum + 26'sd64) >>> 7;
`else
        re_sh = re_sum >>> 7;
        im_sh = im_sum >>> 7;
`endif
        if (re_sh > 26'sd32767) begin
            re_sat = 16'sh7FFF;
        end else if (re_sh < -26'sd32768) begin
            re_sat = 16'sh8000;
        end else begin
            re_sat = re_sh[15:0];
        end
        if (im_sh > 26'sd32767) begin
            im_sat = 16'sh7FFF;
        end else if (im_sh < -26'sd32768) begin
            im_sat = 16'sh8000;
        end else begin
            im_sat = im_sh[15:0];
        end
    end

    logic               out_valid_q, out_last_q;
    logic signed [15:0] out_r_q, out_i_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_last_q;
            // Data is held through bubbles.
            if (s2_valid_q) begin
                out_r_q <= re_sat;
                out_i_q <= im_sat;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;

endmodule

// File: tb/tb_twiddle_mul_stage4.sv
// ---------------------------------------------------------------------------
// tb_twiddle_mul_stage4
//
// Directed bench for twiddle_mul_stage4. The 4-entry twiddle ROM is modelled
// here as a constant lookup: 0 -> 128+j0, 1 -> 90-j90, 2 -> 0-j128,
// 3 -> -90-j90. Expected products are worked out by hand for each vector.
// ---------------------------------------------------------------------------
module tb_twiddle_mul_stage4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_start;
    logic signed [15:0] in_r;
    logic signed [15:0] in_i;
    logic [1:0]         rom_4_counter;
    logic signed [8:0]  w_r;
    logic signed [8:0]  w_i;
    logic               out_valid;
    logic               out_last;
    logic signed [15:0] out_r;
    logic signed [15:0] out_i;

    int errors = 0;
    int checks = 0;

    twiddle_mul_stage4 dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_start      (in_start),
        .in_r          (in_r),
        .in_i          (in_i),
        .rom_4_counter (rom_4_counter),
        .w_r           (w_r),
        .w_i           (w_i),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_r         (out_r),
        .out_i         (out_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        w_r = 9'sd128;
        w_i = 9'sd0;
        case (rom_4_counter)
            2'd1: begin w_r =  9'sd90; w_i = -9'sd90;  end
            2'd2: begin w_r =  9'sd0;  w_i = -9'sd128; end
            2'd3: begin w_r = -9'sd90; w_i = -9'sd90;  end
            default: ;
        endcase
    end

`ifdef TWIDDLE_ROUND_EN
    localparam int FRAME_IDX1_RE = 352;
    localparam int PT5_IM        = -70;
`else
    localparam int FRAME_IDX1_RE = 351;
    localparam int PT5_IM        = -71;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input int r, input int i);
        in_valid = v;
        in_start = s;
        in_r     = 16'(r);
        in_i     = 16'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1234, -77);
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b last=%b required 0 0", out_valid, out_last);
        end
        checks++;
        if (out_r !== 16'sd0 || out_i !== 16'sd0) begin
            errors++;
            $display("FAIL reset_data: out=(%0d,%0d) required (0,0)", out_r, out_i);
        end
        drive(1'b0, 1'b0, 0, 0);
        #1;
        checks++;
        if (rom_4_counter !== 2'd0) begin
            errors++;
            $display("FAIL reset_rom: rom=%0d required 0", rom_4_counter);
        end
        rst = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // 32 back-to-back samples (1000,-500), in_start on the first.
    task automatic test_frame();
        int j;
        int er, ei;
        logic [4:0] c;
        logic [1:0] erom;
        do_reset();
        for (int k = 0; k < 35; k++) begin
            if (k < 32) begin
                drive(1'b1, (k == 0), 1000, -500);
                c = 5'(k);
                erom = c[2] ? c[1:0] : 2'd0;
                #1;
                checks++;
                if (rom_4_counter !== erom) begin
                    errors++;
                    $display("FAIL frame_rom k=%0d: rom=%0d required %0d", k, rom_4_counter, erom);
                end
            end else begin
                drive(1'b0, 1'b0, 0, 0);
            end
            tick();
            j = k - 2;
            if (j >= 0) begin
                c = 5'(j > 31 ? 31 : j);
                er = 1000;  ei = -500;
                if (c[2]) begin
                    case (c[1:0])
                        2'd1: begin er = FRAME_IDX1_RE; ei = -1055; end
                        2'd2: begin er = -500;          ei = -1000; end
                        2'd3: begin er = -1055;         ei = -352;  end
                        default: ;
                    endcase
                end
                checks++;
                if (out_valid !== (j <= 31) || out_last !== (j == 31)) begin
                    errors++;
                    $display("FAIL frame_flags j=%0d: valid=%b last=%b required %b %b",
                             j, out_valid, out_last, (j <= 31), (j == 31));
                end
                checks++;
                if (out_r !== 16'(er) || out_i !== 16'(ei)) begin
                    errors++;
                    $display("FAIL frame_data j=%0d: out=(%0d,%0d) required (%0d,%0d)",
                             j, out_r, out_i, er, ei);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_prefill k=%0d: valid=%b required 0", k, out_valid);
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Specific twiddle points at cnt=5,6,7 including saturation.
    task automatic test_twiddle_points();
        int j;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            case (k)
                5:       drive(1'b1, 1'b0, 100, 0);
                6:       drive(1'b1, 1'b0, 300, 200);
                7:       drive(1'b1, 1'b0, -32768, -32768);
                8, 9:    drive(1'b0, 1'b0, 0, 0);
                default: drive(1'b1, (k == 0), 1000, -500);
            endcase
            #1;
            if (k >= 5 && k <= 7) begin
                checks++;
                if (rom_4_counter !== 2'(k - 4)) begin
                    errors++;
                    $display("FAIL point_rom k=%0d: rom=%0d required %0d", k, rom_4_counter, k - 4);
                end
            end
            tick();
            j = k - 2;
            if (j == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_r !== 16'sd70 || out_i !== 16'(PT5_IM)) begin
                    errors++;
                    $display("FAIL point_cnt5: valid=%b out=(%0d,%0d) required 1 (70,%0d)",
                             out_valid, out_r, out_i, PT5_IM);
                end
            end
            if (j == 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_r !== 16'sd200 || out_i !== -16'sd300) begin
                    errors++;
                    $display("FAIL point_cnt6: valid=%b out=(%0d,%0d) required 1 (200,-300)",
                             out_valid, out_r, out_i);
                end
            end
            if (j == 7) begin
                checks++;
                if (out_valid !== 1'b1 || out_r !== 16'sd0 || out_i !== 16'sd32767) begin
                    errors++;
                    $display("FAIL point_cnt7_sat: valid=%b out=(%0d,%0d) required 1 (0,32767)",
                             out_valid, out_r, out_i);
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Alternating valid, in_start at sample 10, then rst mid-frame.
    // Inputs are (128*m, 0) so every twiddle product is exact:
    // idx0 (x,0), idx1 (90m,-90m), idx2 (0,-x), idx3 (-90m,-90m).
    task automatic test_back_to_back();
        logic       ev [0:70];
        int         er [0:70];
        int         ei [0:70];
        int         s, m, x, j, hr, hi;
        logic [4:0] c;
        logic [1:0] idx;
        do_reset();
        hr = 0;
        hi = 0;
        for (int cy = 0; cy < 65; cy++) begin
            ev[cy] = (cy % 2 == 0);
            er[cy] = 0;
            ei[cy] = 0;
            s = cy / 2;
            m = s + 1;
            x = 128 * m;
            c = 5'(s < 10 ? s : s - 10);
            idx = c[2] ? c[1:0] : 2'd0;
            if (ev[cy]) begin
                case (idx)
                    2'd0: begin er[cy] = x;       ei[cy] = 0;       end
                    2'd1: begin er[cy] = 90 * m;  ei[cy] = -90 * m; end
                    2'd2: begin er[cy] = 0;       ei[cy] = -x;      end
                    default: begin er[cy] = -90 * m; ei[cy] = -90 * m; end
                endcase
                drive(1'b1, (s == 10), x, 0);
                #1;
                checks++;
                if (rom_4_counter !== idx) begin
                    errors++;
                    $display("FAIL alt_rom cy=%0d: rom=%0d required %0d", cy, rom_4_counter, idx);
                end
            end else begin
                // in_start without in_valid must be ignored
                drive(1'b0, 1'b1, 7, 7);
            end
            tick();
            if (cy >= 2) begin
                j = cy - 2;
                if (ev[j]) begin
                    hr = er[j];
                    hi = ei[j];
                end
                checks++;
                if (out_valid !== ev[j] || out_last !== 1'b0 ||
                    out_r !== 16'(hr) || out_i !== 16'(hi)) begin
                    errors++;
                    $display("FAIL alt_out j=%0d: valid=%b last=%b out=(%0d,%0d) required %b 0 (%0d,%0d)",
                             j, out_valid, out_last, out_r, out_i, ev[j], hr, hi);
                end
            end
        end
        // Sample from cycle 64 is still in flight here.
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_r !== 16'sd0 || out_i !== 16'sd0) begin
            errors++;
            $display("FAIL midrst_clear: valid=%b out=(%0d,%0d) required 0 (0,0)",
                     out_valid, out_r, out_i);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale k=%0d: valid=%b last=%b required 0 0",
                         k, out_valid, out_last);
            end
        end
        // First sample after reset is position 0 even without in_start.
        drive(1'b1, 1'b0, 640, 0);
        #1;
        checks++;
        if (rom_4_counter !== 2'd0) begin
            errors++;
            $display("FAIL post_rst_rom: rom=%0d required 0", rom_4_counter);
        end
        tick();
        drive(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_r !== 16'sd640 || out_i !== 16'sd0) begin
            errors++;
            $display("FAIL post_rst_out: valid=%b out=(%0d,%0d) required 1 (640,0)",
                     out_valid, out_r, out_i);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        test_reset();
        test_frame();
        test_twiddle_points();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
